// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared types and constants for the bit-serial adder.
//   serial_adder_state_t       : controller states (IDLE, RUN, DONE)
//   SERIAL_ADDER_DEFAULT_WIDTH : default operand / sum width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_adder_state_t;

    localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder composed of two half adders; the two partial carries
// can never both be set, so a plain OR merges them.
// Ports:
//   a, b  in  1  addend bits
//   cin   in  1  carry in
//   sum   out 1  a ^ b ^ cin
//   cout  out 1  carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_sum;
    logic ab_carry;
    logic abc_carry;

    half_adder u_ha_ab (
        .a    (a),
        .b    (b),
        .sum  (ab_sum),
        .cout (ab_carry)
    );

    half_adder u_ha_abc (
        .a    (ab_sum),
        .b    (cin),
        .sum  (sum),
        .cout (abc_carry)
    );

    assign cout = ab_carry | abc_carry;

endmodule : full_adder

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Team half-adder primitive: one-bit sum and carry of two inputs.
// Ports:
//   a, b  in  1  addend bits
//   sum   out 1  a ^ b
//   cout  out 1  a & b
// -----------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b;
    assign cout = a & b;

endmodule : half_adder

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: accepts two WIDTH-bit operands and a carry-in, adds them
// LSB-first through a single full adder (one bit per clock) and returns the
// WIDTH-bit sum plus carry-out. Both sides use a valid/ready handshake.
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous, active-high reset
//   in_valid   in  1      operands valid
//   in_ready   out 1      block can accept operands (state == IDLE)
//   a, b       in  WIDTH  operands, sampled only on the accepting edge
//   cin        in  1      carry in
//   out_valid  out 1      result valid (state == DONE)
//   out_ready  in  1      consumer accepts result
//   sum        out WIDTH  a + b + cin, modulo 2^WIDTH (registered)
//   cout       out 1      carry out of bit WIDTH-1 (registered)
// -----------------------------------------------------------------------------
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Wide enough to hold WIDTH itself, which keeps WIDTH = 1 legal.
    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serial_adder_state_t state_q;
    logic [WIDTH-1:0]    a_sr_q;
    logic [WIDTH-1:0]    b_sr_q;
    logic [WIDTH-1:0]    sum_sr_q;
    logic                carry_q;
    logic [CNT_W-1:0]    count_q;

    logic fa_sum;
    logic fa_cout;

    full_adder u_full_adder (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // NOTE: every flop here is plain control/datapath state (no memory array),
    // so all of it is cleared by the asynchronous reset; this is what makes an
    // aborted operation vanish without a stray out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the pre-edge value regardless of statement order.
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q   <= a;
                        b_sr_q   <= b;
                        carry_q  <= cin;
                        sum_sr_q <= '0;
                        count_q  <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    carry_q  <= fa_cout;
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    // Insert the new bit at the MSB; after WIDTH shifts the
                    // first bit computed has reached bit 0. Written as a wide
                    // shift so the slice stays legal when WIDTH = 1.
                    sum_sr_q <= WIDTH'({fa_sum, sum_sr_q} >> 1);
                    count_q  <= count_q + CNT_W'(1);
                    if (count_q == LAST_BIT) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake flags decode from state only: no input-to-output path.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr_q;
    assign cout      = carry_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Directed and randomized checks of serial_adder at WIDTH = 8 and WIDTH = 1.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // WIDTH = 8 instance
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] a         = '0;
    logic [7:0] b         = '0;
    logic       cin       = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;

    // WIDTH = 1 instance
    logic       in_valid1  = 1'b0;
    logic       in_ready1;
    logic [0:0] a1         = '0;
    logic [0:0] b1         = '0;
    logic       cin1       = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and return right after the accepting edge; the
    // operand inputs are then scrambled to show they are not re-sampled.
    task automatic start8(input logic [7:0] ai, input logic [7:0] bi, input logic ci);
        a        = ai;
        b        = bi;
        cin      = ci;
        in_valid = 1'b1;
        for (int i = 0; i < 30 && !in_ready; i++) tick();
        check("accept_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        cin      = 1'($urandom);
    endtask

    // Count edges from acceptance until out_valid. In noisy mode in_valid,
    // out_ready and the operands toggle randomly while the adder is busy.
    task automatic wait_done8(input bit noisy, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (noisy) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
                a         = 8'($urandom);
                b         = 8'($urandom);
            end
            tick();
            lat++;
        end
        if (noisy) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
        check("out_valid_rise", out_valid, 1);
    endtask

    initial begin
        int       lat;
        bit       seen;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] exp9;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
        check("rst_w1_in_ready", in_ready1, 1);
        check("rst_w1_out_valid", out_valid1, 0);
        rst = 1'b0;
        tick();

        // ---------------- 0 + 0 + 0, out_ready high ----------------
        out_ready = 1'b1;
        start8(8'h00, 8'h00, 1'b0);
        wait_done8(1'b0, lat);
        check("zero_latency", lat, 8);
        check("zero_sum", sum, 8'h00);
        check("zero_cout", cout, 0);
        check("zero_in_ready_busy", in_ready, 0);
        tick();
        check("zero_in_ready_back", in_ready, 1);
        check("zero_out_valid_drop", out_valid, 0);

        // ---------------- FF + 01, then 3C + 0F back-to-back ----------------
        start8(8'hFF, 8'h01, 1'b0);
        wait_done8(1'b0, lat);
        check("ff01_sum", sum, 8'h00);
        check("ff01_cout", cout, 1);
        start8(8'h3C, 8'h0F, 1'b0);
        wait_done8(1'b0, lat);
        check("3c0f_latency", lat, 8);
        check("3c0f_sum", sum, 8'h4B);
        check("3c0f_cout", cout, 0);

        // ---------------- backpressure: A5 + 5A + 1 ----------------
        tick();
        out_ready = 1'b0;
        start8(8'hA5, 8'h5A, 1'b1);
        wait_done8(1'b0, lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_sum", sum, 8'h00);
            check("bp_cout", cout, 1);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            in_valid = (i % 2 == 0);
            a        = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("bp_sum_end", sum, 8'h00);
        check("bp_cout_end", cout, 1);
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);

        // ---------------- reset mid-RUN ----------------
        start8(8'h7F, 8'h01, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("abort_async_in_ready", in_ready, 1);
        check("abort_async_out_valid", out_valid, 0);
        check("abort_async_sum", sum, 8'h00);
        check("abort_async_cout", cout, 0);
        tick();
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", seen, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_sum", sum, 8'h00);
        start8(8'h10, 8'h20, 1'b0);
        wait_done8(1'b0, lat);
        check("post_abort_sum", sum, 8'h30);
        check("post_abort_cout", cout, 0);
        tick();

        // ---------------- WIDTH = 1, all input combinations ----------------
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1        = 1'(i >> 2);
            b1        = 1'(i >> 1);
            cin1      = 1'(i);
            in_valid1 = 1'b1;
            for (int j = 0; j < 10 && !in_ready1; j++) tick();
            check("w1_ready", in_ready1, 1);
            tick();
            in_valid1 = 1'b0;
            check("w1_busy", out_valid1, 0);
            tick();
            check("w1_out_valid", out_valid1, 1);
            check("w1_result", {cout1, sum1}, ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
            tick();
        end

        // ---------------- random operations with stalls ----------------
        out_ready = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            for (int d = $urandom_range(0, 3); d > 0; d--) tick();
            start8(ra, rb, rc);
            wait_done8(1'b1, lat);
            check("rnd_latency", lat, 8);
            for (int d = $urandom_range(0, 3); d > 0; d--) tick();
            check("rnd_result", {cout, sum}, exp9);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("rnd_in_ready", in_ready, 1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_serial_adder
